// File: rtl/tetris_pkg.sv
// Shared tetris definitions: gamepad button indices and the serial reader state encoding.
package tetris_pkg;

    localparam int NUM_BUTTONS = 12;

    // Bit positions match the order the SNES pad shifts its report out.
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SAMPLE,
        CLK_LOW,
        DONE
    } reader_state_t;

endpackage

// File: rtl/counter.sv
// Generic up/down counter with synchronous load; clears on asynchronous reset.
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            q <= '0;
        end else if (en) begin
            if (load)    q <= d;
            else if (up) q <= q + 1'b1;
            else         q <= q - 1'b1;
        end
    end

endmodule

// File: rtl/snes_controller_reader.sv
// Polls an SNES gamepad at a fixed rate and publishes the 12 button levels with a valid strobe.
module snes_controller_reader
    import tetris_pkg::*;
#(
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 300,
    parameter int POLL_CYCLES  = 833_333,
    parameter int NUM_BITS     = 16
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   ctrl_data,
    output logic                   ctrl_latch,
    output logic                   ctrl_pulse,
    output logic [NUM_BUTTONS-1:0] buttons,
    output logic                   buttons_valid,
    output logic                   busy
);

    localparam int TXN_CYCLES = LATCH_CYCLES + (2*NUM_BITS-1)*HALF_CYCLES + 1;
    localparam int PHASE_MAX  = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int POLL_W     = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int PHASE_W    = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam int BIT_W      = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    if (POLL_CYCLES <= TXN_CYCLES) begin : g_poll_too_short
        $error("POLL_CYCLES must exceed the transaction length");
    end
    if (NUM_BITS < NUM_BUTTONS) begin : g_too_few_bits
        $error("NUM_BITS must cover all buttons");
    end

    reader_state_t       state, state_next;
    logic [1:0]          data_sync;
    logic                data_s;
    logic [POLL_W-1:0]   poll_cnt;
    logic [PHASE_W-1:0]  phase_cnt;
    logic [BIT_W-1:0]    bit_idx;
    logic [NUM_BITS-1:0] shift;
    logic                poll_last, phase_last, phase_clr, bit_en, sample_en;

    // Idle level of the pulled-up data line is high.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) data_sync <= 2'b11;
        else        data_sync <= {data_sync[0], ctrl_data};
    end
    assign data_s = data_sync[1];

    assign poll_last = (poll_cnt == POLL_W'(POLL_CYCLES-1));

    always_comb begin
        phase_last = 1'b0;
        case (state)
            LATCH:           phase_last = (phase_cnt == PHASE_W'(LATCH_CYCLES-1));
            SAMPLE, CLK_LOW: phase_last = (phase_cnt == PHASE_W'(HALF_CYCLES-1));
            default:         phase_last = 1'b0;
        endcase
    end

    assign phase_clr = (state == IDLE) || (state == DONE) || phase_last;
    assign bit_en    = (state == LATCH) || ((state == CLK_LOW) && phase_last);
    assign sample_en = (state == SAMPLE) && phase_last;

    counter #(.WIDTH(POLL_W)) u_poll_cnt (
        .clk(clk), .rst_l(rst_l), .en(1'b1), .load(poll_last), .up(1'b1),
        .d('0), .q(poll_cnt)
    );

    counter #(.WIDTH(PHASE_W)) u_phase_cnt (
        .clk(clk), .rst_l(rst_l), .en(1'b1), .load(phase_clr), .up(1'b1),
        .d('0), .q(phase_cnt)
    );

    counter #(.WIDTH(BIT_W)) u_bit_cnt (
        .clk(clk), .rst_l(rst_l), .en(bit_en), .load(state == LATCH), .up(1'b1),
        .d('0), .q(bit_idx)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (poll_last)  state_next = LATCH;
            LATCH:   if (phase_last) state_next = SAMPLE;
            SAMPLE:  if (phase_last) state_next = (bit_idx == BIT_W'(NUM_BITS-1)) ? DONE : CLK_LOW;
            CLK_LOW: if (phase_last) state_next = SAMPLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pad lines are decoded from the next state so they align exactly with the state register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ctrl_latch    <= 1'b0;
            ctrl_pulse    <= 1'b1;
            buttons       <= '0;
            buttons_valid <= 1'b0;
            shift         <= '1;
        end else begin
            ctrl_latch    <= (state_next == LATCH);
            ctrl_pulse    <= (state_next != CLK_LOW);
            buttons_valid <= (state == DONE);
            if (sample_en)       shift[bit_idx] <= data_s;
            if (state == DONE)   buttons <= ~shift[NUM_BUTTONS-1:0];
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_snes_controller_reader.sv
// Directed and randomized checks of the SNES reader against a behavioural gamepad model.
module tb_snes_controller_reader;
    import tetris_pkg::*;

    localparam int LC  = 4;
    localparam int HC  = 3;
    localparam int PC  = 200;
    localparam int NB  = 16;
    localparam int TXN = LC + (2*NB-1)*HC + 1;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        ctrl_data = 1'b1;
    logic        ctrl_latch, ctrl_pulse, buttons_valid, busy;
    logic [11:0] buttons;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snes_controller_reader #(
        .LATCH_CYCLES(LC), .HALF_CYCLES(HC), .POLL_CYCLES(PC), .NUM_BITS(NB)
    ) dut (
        .clk(clk), .rst_l(rst_l), .ctrl_data(ctrl_data),
        .ctrl_latch(ctrl_latch), .ctrl_pulse(ctrl_pulse),
        .buttons(buttons), .buttons_valid(buttons_valid), .busy(busy)
    );

    // Gamepad model: latch reloads the report, each rising clock edge presents the next bit.
    logic [15:0] rep = 16'hFFFF;
    int          idx = 0;
    bit          glitch_en = 1'b0;

    always @(posedge ctrl_latch or posedge ctrl_pulse or negedge ctrl_pulse) begin
        if (ctrl_latch)      idx = 0;
        else if (ctrl_pulse) idx = idx + 1;
        if (glitch_en) begin
            repeat (3) begin
                ctrl_data = 1'($urandom);
                #1;
            end
        end
        ctrl_data = (idx < 16) ? rep[idx] : 1'b1;
    end

    // Cycle count since reset release; edge n after release reads n.
    int cyc = 0;
    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    logic        prev_pulse = 1'b1, prev_latch = 1'b0;
    logic [11:0] prev_btn = '0;
    int falls = 0, latch_rise_cyc = -1, nrise = 0, latch_w = 0, latch_run = 0;
    int nvalid = 0, bad_change = 0;

    always @(negedge clk) begin
        if (ctrl_latch && !prev_latch) begin
            falls          <= 0;
            latch_rise_cyc <= cyc;
            nrise          <= nrise + 1;
            latch_run      <= 1;
        end else begin
            if (ctrl_latch)                latch_run <= latch_run + 1;
            if (!ctrl_latch && prev_latch) latch_w   <= latch_run;
            if (prev_pulse && !ctrl_pulse) falls     <= falls + 1;
        end
        if (buttons_valid === 1'b1) nvalid <= nvalid + 1;
        if (rst_l && buttons_valid !== 1'b1 && buttons !== prev_btn) bad_change <= bad_change + 1;
        prev_pulse <= ctrl_pulse;
        prev_latch <= ctrl_latch;
        prev_btn   <= buttons;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < 2*PC; i++) begin
            @(negedge clk);
            #1;
            if (buttons_valid === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    // Line levels are active-low; bits above the buttons carry junk.
    function automatic logic [15:0] report(input logic [11:0] pressed, input logic [3:0] junk);
        return ~{junk, pressed};
    endfunction

    initial begin
        int          at, prev_at, nv, nr;
        bit          ok;
        logic [11:0] mask;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_latch", 32'(ctrl_latch), 0);
        chk("rst_pulse", 32'(ctrl_pulse), 1);
        chk("rst_buttons", 32'(buttons), 0);
        chk("rst_valid", 32'(buttons_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_l = 1'b1;

        // 1: idle pad reads nothing pressed
        wait_strobe(at, ok);
        chk("t1_strobe_seen", 32'(ok), 1);
        chk("t1_strobe_cyc", 32'(at), 32'(PC + TXN));
        chk("t1_buttons", 32'(buttons), 0);
        chk("t1_latch_rise", 32'(latch_rise_cyc), 32'(PC));
        chk("t1_latch_width", 32'(latch_w), 32'(LC));
        chk("t1_falls", 32'(falls), 32'(NB - 1));
        chk("t1_nvalid", 32'(nvalid), 1);
        @(negedge clk);
        #1;
        chk("t1_valid_one_cycle", 32'(buttons_valid), 0);
        chk("t1_busy_low", 32'(busy), 0);
        prev_at = at;

        // 2: B and R
        mask = 12'(1 << BTN_B) | 12'(1 << BTN_R);
        rep  = report(mask, 4'h0);
        wait_strobe(at, ok);
        chk("t2_strobe_seen", 32'(ok), 1);
        chk("t2_period", 32'(at - prev_at), 32'(PC));
        chk("t2_buttons", 32'(buttons), 32'(mask));
        prev_at = at;

        // 3: Up and Left
        mask = 12'(1 << BTN_UP) | 12'(1 << BTN_LEFT);
        rep  = report(mask, 4'h0);
        wait_strobe(at, ok);
        chk("t3_period", 32'(at - prev_at), 32'(PC));
        chk("t3_buttons", 32'(buttons), 32'(mask));
        prev_at = at;

        // 4: junk in the discarded bits only
        rep = report(12'h000, 4'hF);
        wait_strobe(at, ok);
        chk("t4_period", 32'(at - prev_at), 32'(PC));
        chk("t4_buttons", 32'(buttons), 0);
        chk("hold_between_strobes", 32'(bad_change), 0);

        // 5: reset while the pad clock is low after bit 7
        mask = 12'($urandom);
        rep  = report(mask, 4'($urandom));
        nr   = nrise;
        ok   = 1'b0;
        for (int i = 0; i < 2*PC; i++) begin
            @(negedge clk);
            #1;
            if (nrise != nr && falls == 8 && ctrl_pulse === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t5_reached_bit7_low", 32'(ok), 1);
        nv = nvalid;
        rst_l = 1'b0;
        #1;
        chk("t5_pulse", 32'(ctrl_pulse), 1);
        chk("t5_latch", 32'(ctrl_latch), 0);
        chk("t5_buttons", 32'(buttons), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_valid", 32'(buttons_valid), 0);
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        nr = nrise;
        ok = 1'b0;
        for (int i = 0; i < 2*PC; i++) begin
            @(negedge clk);
            #1;
            if (nrise != nr) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t5_relatch_seen", 32'(ok), 1);
        chk("t5_relatch_cyc", 32'(latch_rise_cyc), 32'(PC));
        chk("t5_no_partial", 32'(nvalid), 32'(nv));
        wait_strobe(at, ok);
        chk("t5_strobe_cyc", 32'(at), 32'(PC + TXN));
        chk("t5_buttons_after", 32'(buttons), 32'(mask));
        prev_at = at;

        // 6: random reports with the data line glitching outside the sample window
        glitch_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mask = 12'($urandom);
            rep  = report(mask, 4'($urandom));
            wait_strobe(at, ok);
            chk("t6_period", 32'(at - prev_at), 32'(PC));
            chk("t6_buttons", 32'(buttons), 32'(mask));
            chk("t6_falls", 32'(falls), 32'(NB - 1));
            prev_at = at;
        end
        chk("t6_hold_between_strobes", 32'(bad_change), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
